fnd_scan_driver: RTL

Time-multiplexed 3-digit seven-segment (FND) driver consuming the BCD seconds digits produced by the game timer (`Sec0` least significant, `Sec2` most significant). It snapshots the digits once per scan frame, so a frame never mixes old and new values. It decodes each digit to segment patterns and scans the common lines with a dead-time gap between digits to suppress ghosting. It sits between the timer and the board FND pins in the maze top level.

---
 rtl/fnd_pkg.sv | 25 ++
 rtl/bcd_to_seg.sv | 26 ++
 rtl/fnd_scan_driver.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fnd_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment order is {g,f,e,d,c,b,a}, active-high; commons are active-low.
package fnd_pkg;

    typedef enum logic {
        S_DEAD = 1'b0,
        S_ON   = 1'b1
    } state_t;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    localparam logic [2:0] COM_OFF  = 3'b111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; non-decimal codes show a dash.
module bcd_to_seg
    import fnd_pkg::*;
(
    input  logic [3:0] i_Bcd,
    output logic [6:0] o_Seg
);

    always_comb begin
        o_Seg = SEG_DASH;
        case (i_Bcd)
            4'd0:    o_Seg = SEG_0;
            4'd1:    o_Seg = SEG_1;
            4'd2:    o_Seg = SEG_2;
            4'd3:    o_Seg = SEG_3;
            4'd4:    o_Seg = SEG_4;
            4'd5:    o_Seg = SEG_5;
            4'd6:    o_Seg = SEG_6;
            4'd7:    o_Seg = SEG_7;
            4'd8:    o_Seg = SEG_8;
            4'd9:    o_Seg = SEG_9;
            default: o_Seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/fnd_scan_driver.sv
// Three-digit multiplexed FND driver: per-frame digit snapshot, dead-time
// between commons, leading-zero blanking and registered pin outputs.
module fnd_scan_driver
    import fnd_pkg::*;
#(
    parameter int unsigned ON_CLK   = 99_000,
    parameter int unsigned DEAD_CLK = 1_000,
    parameter int          DP_POS   = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [3:0] i_Dig0,
    input  logic [3:0] i_Dig1,
    input  logic [3:0] i_Dig2,
    input  logic       i_Blank,
    input  logic       i_Hold,
    output logic [2:0] o_Com,
    output logic [6:0] o_Seg,
    output logic       o_Dp
);

    localparam logic [19:0] ON_LAST   = 20'(ON_CLK - 1);
    localparam logic [19:0] DEAD_LAST = 20'(DEAD_CLK - 1);
    localparam logic [1:0]  DP_IDX    = 2'(DP_POS);

    state_t          state_reg, state_next;
    logic [19:0]     cnt_reg, cnt_next;
    logic [1:0]      idx_reg, idx_next;
    logic [2:0][3:0] shadow_reg, shadow_next, dig_in;
    logic [2:0]      zero_vec, prot_vec, blank_vec;
    logic            snap_en;
    logic [3:0]      cur_bcd;
    logic [6:0]      cur_seg;
    logic [2:0]      com_next;
    logic [6:0]      seg_next;
    logic            dp_next;

    assign dig_in  = {i_Dig2, i_Dig1, i_Dig0};
    assign snap_en = (state_reg == S_DEAD) && (idx_reg == 2'd0) &&
                     (cnt_reg == 20'd0) && !i_Hold;

    // A digit at or right of the lit decimal point is never blanked;
    // DP_POS = 3 means no decimal point, so nothing is protected.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_digit
            assign shadow_next[gi] = snap_en ? dig_in[gi] : shadow_reg[gi];
            assign zero_vec[gi]    = (shadow_next[gi] == 4'd0);
            assign prot_vec[gi]    = (DP_POS >= gi) && (DP_POS <= 2);
        end
    endgenerate

    assign blank_vec[2] = i_Blank & zero_vec[2] & ~prot_vec[2];
    assign blank_vec[1] = blank_vec[2] & zero_vec[1] & ~prot_vec[1];
    assign blank_vec[0] = 1'b0;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 20'd1;
        idx_next   = idx_reg;
        case (state_reg)
            S_DEAD: begin
                if (cnt_reg == DEAD_LAST) begin
                    cnt_next   = 20'd0;
                    state_next = S_ON;
                end
            end
            S_ON: begin
                if (cnt_reg == ON_LAST) begin
                    cnt_next   = 20'd0;
                    idx_next   = (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
                    state_next = S_DEAD;
                end
            end
            default: begin
                cnt_next   = 20'd0;
                idx_next   = 2'd0;
                state_next = S_DEAD;
            end
        endcase
    end

    // Outputs are computed from the next state so the pins change on the
    // same edge as the state/index transition.
    always_comb begin
        cur_bcd = 4'd0;
        case (idx_next)
            2'd0:    cur_bcd = shadow_next[0];
            2'd1:    cur_bcd = shadow_next[1];
            2'd2:    cur_bcd = shadow_next[2];
            default: cur_bcd = 4'd0;
        endcase
    end

    bcd_to_seg u_dec (
        .i_Bcd (cur_bcd),
        .o_Seg (cur_seg)
    );

    always_comb begin
        com_next = COM_OFF;
        seg_next = SEG_OFF;
        dp_next  = 1'b0;
        if (state_next == S_ON) begin
            com_next = ~(3'b001 << idx_next);
            seg_next = blank_vec[idx_next] ? SEG_OFF : cur_seg;
            dp_next  = (idx_next == DP_IDX);
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_reg  <= S_DEAD;
            cnt_reg    <= 20'd0;
            idx_reg    <= 2'd0;
            shadow_reg <= '0;
            o_Com      <= COM_OFF;
            o_Seg      <= SEG_OFF;
            o_Dp       <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            shadow_reg <= shadow_next;
            o_Com      <= com_next;
            o_Seg      <= seg_next;
            o_Dp       <= dp_next;
        end
    end

endmodule
